// File: rtl/systolic_out_collector_pkg.sv
// Shared types and index helpers for the systolic output collector and its
// partner activation driver, so both sides agree on the capture skew order.
package systolic_out_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKEW,
        ST_CAPTURE,
        ST_DRAIN
    } state_e;

    function automatic int row_bits(input int dim_x, input int lane_bits);
        return dim_x * lane_bits;
    endfunction

    function automatic int idx_bits(input int dim_y);
        return (dim_y > 1) ? $clog2(dim_y) : 1;
    endfunction

    // Buffer slot written by capture beat c: 0, Y-1, Y-2, ..., 1.
    function automatic int wa_index(input int c, input int dim_y);
        return (dim_y - (c % dim_y)) % dim_y;
    endfunction

endpackage

// File: rtl/systolic_out_collector_out_row_buffer.sv
// Row register file: one write port, two asynchronous read ports. A read in
// the same cycle as a write to that entry returns the old contents.
module out_row_buffer #(
    parameter int DEPTH    = 16,
    parameter int ROW_BITS = 512,
    parameter int IDX_BITS = 4
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [IDX_BITS-1:0] waddr_i,
    input  logic [ROW_BITS-1:0] wdata_i,
    input  logic [IDX_BITS-1:0] raddr_a_i,
    output logic [ROW_BITS-1:0] rdata_a_o,
    input  logic [IDX_BITS-1:0] raddr_b_i,
    output logic [ROW_BITS-1:0] rdata_b_o
);

    logic [ROW_BITS-1:0] mem_q [DEPTH];

    // NOTE: the storage array has no reset; every entry is written before it
    // is read on a first pass, and a reset net fanned out to it buys nothing.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/systolic_out_collector.sv
// Collects skewed array output rows, feeds partial sums back for multi-pass
// accumulation and drains the finished tile over a valid/ready stream.
module systolic_out_collector
    import systolic_out_collector_pkg::*;
#(
    parameter int  ARRAY_DIM_X       = 16,
    parameter int  ARRAY_DIM_Y       = 16,
    parameter int  OUT_DATA_BITWIDTH = 32,
    parameter int  SKEW_BEATS        = 16,
    localparam int ROW_BITS          = row_bits(ARRAY_DIM_X, OUT_DATA_BITWIDTH),
    localparam int IDX_BITS          = idx_bits(ARRAY_DIM_Y)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                first_pass,
    input  logic                last_pass,
    input  logic                in_valid,
    input  logic [ROW_BITS-1:0] data_out,
    output logic [ROW_BITS-1:0] part_out_in,
    output logic [ROW_BITS-1:0] out_data,
    output logic [IDX_BITS-1:0] out_row,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    localparam int CNT_MAX  = (SKEW_BEATS > ARRAY_DIM_Y) ? SKEW_BEATS : ARRAY_DIM_Y;
    localparam int CNT_BITS = $clog2(CNT_MAX + 1);
    localparam logic [CNT_BITS-1:0] SKEW_LAST = CNT_BITS'(SKEW_BEATS - 1);
    localparam logic [CNT_BITS-1:0] CAP_LAST  = CNT_BITS'(ARRAY_DIM_Y - 1);
    localparam logic [IDX_BITS-1:0] ROW_LAST  = IDX_BITS'(ARRAY_DIM_Y - 1);

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                first_q, first_d;
    logic                last_q, last_d;
    logic [ROW_BITS-1:0] fb_q, fb_d;
    logic [IDX_BITS-1:0] row_q, row_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;

    logic                buf_we;
    logic [IDX_BITS-1:0] buf_waddr;
    logic [IDX_BITS-1:0] fb_raddr;
    logic [ROW_BITS-1:0] fb_rdata;
    logic [ROW_BITS-1:0] dr_rdata;

    out_row_buffer #(
        .DEPTH    (ARRAY_DIM_Y),
        .ROW_BITS (ROW_BITS),
        .IDX_BITS (IDX_BITS)
    ) u_buf (
        .clk       (clk),
        .we_i      (buf_we),
        .waddr_i   (buf_waddr),
        .wdata_i   (data_out),
        .raddr_a_i (fb_raddr),
        .rdata_a_o (fb_rdata),
        .raddr_b_i (row_q),
        .rdata_b_o (dr_rdata)
    );

    // NOTE: every signal gets its default before the case so no path through
    // the block leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        last_d    = last_q;
        fb_d      = fb_q;
        row_d     = row_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = IDX_BITS'(wa_index(int'(cnt_q), ARRAY_DIM_Y));
        // Feedback is fetched one beat early: slot for c=0 during SKEW, c+1 in CAPTURE.
        fb_raddr  = (state_q == ST_SKEW) ? '0
                  : IDX_BITS'(wa_index(int'(cnt_q) + 1, ARRAY_DIM_Y));

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    first_d = first_pass;
                    last_d  = last_pass;
                    cnt_d   = '0;
                    state_d = ST_SKEW;
                end
            end
            ST_SKEW: begin
                if (in_valid) begin
                    if (cnt_q == SKEW_LAST) begin
                        cnt_d   = '0;
                        fb_d    = first_q ? '0 : fb_rdata;
                        state_d = ST_CAPTURE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                if (in_valid) begin
                    buf_we = 1'b1;
                    if (cnt_q == CAP_LAST) begin
                        cnt_d = '0;
                        fb_d  = '0;
                        if (last_q) begin
                            row_d   = '0;
                            valid_d = 1'b1;
                            state_d = ST_DRAIN;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        fb_d  = first_q ? '0 : fb_rdata;
                    end
                end
            end
            ST_DRAIN: begin
                if (valid_q && out_ready) begin
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            fb_q    <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            last_q  <= last_d;
            fb_q    <= fb_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign part_out_in = fb_q;
    // The buffer is static during DRAIN, so the row read is stable while stalled.
    assign out_data    = valid_q ? dr_rdata : '0;
    assign out_row     = row_q;
    assign out_valid   = valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_systolic_out_collector.sv
// Randomized self-checking bench for systolic_out_collector against a
// tile-level model of buffer contents, feedback words and drain order.
module tb_systolic_out_collector;

    localparam int X    = 16;
    localparam int Y    = 16;
    localparam int W    = 32;
    localparam int SKEW = 16;
    localparam int RB   = X * W;

    typedef logic [RB-1:0] row_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       first_pass = 1'b0;
    logic       last_pass = 1'b0;
    logic       in_valid = 1'b0;
    row_t       data_out = '0;
    row_t       part_out_in;
    row_t       out_data;
    logic [3:0] out_row;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;

    int   n_checks = 0;
    int   n_errors = 0;
    row_t model_mem [Y];

    systolic_out_collector #(
        .ARRAY_DIM_X       (X),
        .ARRAY_DIM_Y       (Y),
        .OUT_DATA_BITWIDTH (W),
        .SKEW_BEATS        (SKEW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .first_pass  (first_pass),
        .last_pass   (last_pass),
        .in_valid    (in_valid),
        .data_out    (data_out),
        .part_out_in (part_out_in),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input row_t obs, input row_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic row_t rep(input logic [W-1:0] v);
        row_t r;
        for (int i = 0; i < X; i++) r[i*W +: W] = v;
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < X; i++) r[i*W +: W] = $urandom;
        return r;
    endfunction

    function automatic int slot(input int c);
        return (Y - c) % Y;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_fb"},    part_out_in, '0);
        check({tag, "_odata"}, out_data, '0);
        check({tag, "_orow"},  row_t'(out_row), '0);
        check({tag, "_ovld"},  row_t'(out_valid), '0);
        check({tag, "_busy"},  row_t'(busy), '0);
        check({tag, "_done"},  row_t'(done), '0);
    endtask

    // dmode: 0 -> lanes c+1, 1 -> lanes 100, 2 -> random
    // vmode/rmode: 0 -> always 1, 1 -> pattern, 2 -> random
    task automatic run_pass(input bit first, input bit last, input int dmode,
                            input int vmode, input int rmode, input bit glitch,
                            input int abort_c);
        int   k;
        int   cyc;
        int   r;
        bit   v;
        bit   rdy;
        row_t word;
        row_t exp_fb;

        first_pass = first;
        last_pass  = last;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        first_pass = ~first;
        last_pass  = ~last;
        check("start_busy", row_t'(busy), 1);

        k   = 0;
        cyc = 0;
        while (k < SKEW + Y) begin
            exp_fb = (k < SKEW || first) ? '0 : model_mem[slot(k - SKEW)];
            check("feedback", part_out_in, exp_fb);
            check("run_busy", row_t'(busy), 1);
            check("run_done", row_t'(done), 0);
            if (abort_c >= 0 && k == SKEW + abort_c) begin
                #2 reset_n = 1'b0;
                #1;
                check_all_zero("abort");
                @(posedge clk);
                #1;
                check_all_zero("abort_hold");
                reset_n  = 1'b1;
                in_valid = 1'b0;
                return;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            case (dmode)
                0:       word = rep(W'(k - SKEW + 1));
                1:       word = rep(W'(100));
                default: word = rand_row();
            endcase
            in_valid = v;
            data_out = (v && k >= SKEW) ? word : rand_row();
            if (glitch && v && k == SKEW + 3) start = 1'b1;
            tick();
            start = 1'b0;
            if (v) begin
                if (k >= SKEW) model_mem[slot(k - SKEW)] = word;
                k++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        check("fb_cleared", part_out_in, '0);

        if (!last) begin
            check("pass_done", row_t'(done), 1);
            check("pass_idle", row_t'(busy), 0);
            check("pass_ovld", row_t'(out_valid), 0);
            tick();
            check("pass_done_end", row_t'(done), 0);
            return;
        end

        r   = 0;
        cyc = 0;
        while (r < Y && cyc < 400) begin
            check("drain_valid", row_t'(out_valid), 1);
            check("drain_row",   row_t'(out_row), row_t'(r));
            check("drain_data",  out_data, model_mem[r]);
            check("drain_done",  row_t'(done), 0);
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = $urandom_range(0, 1) != 0;
            endcase
            out_ready = rdy;
            in_valid  = $urandom_range(0, 1) != 0;
            data_out  = rand_row();
            tick();
            if (rdy) r++;
            cyc++;
        end
        if (r < Y) check("drain_timeout", row_t'(r), row_t'(Y));
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("drain_end_ovld", row_t'(out_valid), 0);
        check("drain_end_done", row_t'(done), 1);
        check("drain_end_busy", row_t'(busy), 0);
        tick();
        check("drain_done_end", row_t'(done), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        #12;
        check_all_zero("reset");
        tick();
        reset_n = 1'b1;
        tick();
        check_all_zero("idle");

        // single pass: first+last, lanes c+1
        run_pass(1'b1, 1'b1, 0, 0, 0, 1'b0, -1);
        // two passes: feedback returns the pass-1 words
        run_pass(1'b1, 1'b0, 0, 0, 0, 1'b0, -1);
        run_pass(1'b0, 1'b1, 1, 0, 0, 1'b0, -1);
        // in_valid toggling every cycle
        run_pass(1'b1, 1'b1, 0, 1, 0, 1'b0, -1);
        // drain backpressure 1,0,0,1
        run_pass(1'b1, 1'b1, 0, 0, 1, 1'b0, -1);
        // stray start during capture
        run_pass(1'b0, 1'b1, 2, 0, 0, 1'b1, -1);
        // reset at capture c=5, then a clean pass
        run_pass(1'b0, 1'b1, 2, 0, 0, 1'b0, 5);
        tick();
        check_all_zero("post_abort");
        run_pass(1'b1, 1'b1, 0, 0, 0, 1'b0, -1);
        // randomized multi-pass traffic
        for (int i = 0; i < 6; i++) begin
            run_pass(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2,
                     $urandom_range(0, 2), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)), -1);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
